sel_mem_seq: RTL and testbench

Parametrised selector memory for the autoencoder datapath. Holds `DEPTH` selector words of `WIDTH` bits, written one at a time through a random-access write port. On a start pulse it replays entries `0..last_idx` in order on a registered valid/ready output stream, so downstream weight/feature muxes can be stepped through a programmed selection sequence. It generalises the single 4-bit enable-load selector register into a sequenced bank with handshake, forwarding and completion signalling.

---
 rtl/sel_mem_seq_if.sv | 33 +++
 rtl/sel_mem_seq.sv | 121 ++++++++++++
 tb/tb_sel_mem_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sel_mem_seq_if.sv
// ============================================================================
// sel_mem_seq_if : write port, replay control and output stream of sel_mem_seq
// Revision 1.0
// ============================================================================
`default_nettype none

interface sel_mem_seq_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 3
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [AW-1:0]    last_idx;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output wr_en, wr_addr, wr_data, start, last_idx, out_ready,
    input  data_out, out_valid, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, last_idx, out_ready,
    output data_out, out_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/sel_mem_seq.sv
// ============================================================================
// sel_mem_seq : selector memory replayed 0..last on a valid/ready stream
// Revision 1.0
// ============================================================================
`default_nettype none

module sel_mem_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  wire logic       clk,
  input  wire logic       rst,
  sel_mem_seq_if.slave    bus
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    last;
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_ok;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    last_clamped;
  logic             xfer;

  assign wr_ok        = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W);
  assign last_clamped = ({1'b0, bus.last_idx} >= DEPTH_W) ? LAST_MAX : bus.last_idx;
  assign xfer         = valid_reg && bus.out_ready;

  // Write-first: a load from the entry being written this cycle sees wr_data.
  always_comb begin
    rd_idx  = (state == S_IDLE) ? '0 : ptr + AW'(1);
    rd_data = mem[rd_idx];
    if (wr_ok && (bus.wr_addr == rd_idx)) begin
      rd_data = bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      last      <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            last      <= last_clamped;
            ptr       <= '0;
            data_reg  <= rd_data;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (ptr == last) begin
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state     <= S_DONE;
            end else begin
              ptr      <= ptr + AW'(1);
              data_reg <= rd_data;
            end
          end
        end
        S_DONE: begin
          done_reg <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out  = data_reg;
  assign bus.out_valid = valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

`default_nettype wire

// File: tb/tb_sel_mem_seq.sv
// ============================================================================
// tb_sel_mem_seq : directed vector table plus multi-cycle sequences
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sel_mem_seq;

  logic clk;
  logic rst;

  sel_mem_seq_if #(.WIDTH(4), .AW(3)) ifa ();
  sel_mem_seq_if #(.WIDTH(4), .AW(3)) ifb ();

  sel_mem_seq #(.WIDTH(4), .DEPTH(8), .AW(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  sel_mem_seq #(.WIDTH(4), .DEPTH(6), .AW(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [3:0] wd;
    logic       st;
    logic [2:0] li;
    logic       rdy;
    logic [3:0] ed;
    logic       ev;
    logic       eb;
    logic       edn;
  } vec_t;

  vec_t tbl[$];
  int   vectors;
  int   miscompares;

  function automatic void add(logic we, logic [2:0] wa, logic [3:0] wd, logic st,
                              logic [2:0] li, logic rdy, logic [3:0] ed,
                              logic ev, logic eb, logic edn);
    vec_t v;
    v = '{we, wa, wd, st, li, rdy, ed, ev, eb, edn};
    tbl.push_back(v);
  endfunction

  function automatic void v_start(logic [2:0] li, logic [3:0] d); add(0, 0, 0, 1, li, 1, d, 1, 1, 0); endfunction
  function automatic void v_run(logic [3:0] d);   add(0, 0, 0, 0, 0, 1, d, 1, 1, 0); endfunction
  function automatic void v_stall(logic [3:0] d); add(0, 0, 0, 0, 0, 0, d, 1, 1, 0); endfunction
  function automatic void v_done(logic [3:0] d);  add(0, 0, 0, 0, 0, 1, d, 0, 0, 1); endfunction
  function automatic void v_idle(logic [3:0] d);  add(0, 0, 0, 0, 0, 1, d, 0, 0, 0); endfunction
  function automatic void v_wr(logic [2:0] a, logic [3:0] x, logic [3:0] d);
    add(1, a, x, 0, 0, 1, d, 0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got data=%h valid=%b busy=%b done=%b, expected data=%h valid=%b busy=%b done=%b",
               name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [6:0] outs_a();
    return {ifa.data_out, ifa.out_valid, ifa.busy, ifa.done};
  endfunction

  function automatic logic [6:0] outs_b();
    return {ifb.data_out, ifb.out_valid, ifb.busy, ifb.done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [3:0] d);
    ifb.wr_en   = 1'b1;
    ifb.wr_addr = a;
    ifb.wr_data = d;
    step();
    ifb.wr_en   = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_b [6];
    vectors     = 0;
    miscompares = 0;

    // Empty memory replay
    v_start(7, 0);
    for (int k = 0; k < 7; k++) v_run(0);
    v_done(0); v_idle(0);
    // Program 3,1,4,1,5,9,2,6 and replay all
    v_wr(0, 3, 0); v_wr(1, 1, 0); v_wr(2, 4, 0); v_wr(3, 1, 0);
    v_wr(4, 5, 0); v_wr(5, 9, 0); v_wr(6, 2, 0); v_wr(7, 6, 0);
    v_start(7, 3);
    v_run(1); v_run(4); v_run(1); v_run(5); v_run(9); v_run(2); v_run(6);
    v_done(6); v_idle(6);
    // Backpressure on word 1, start in RUN and in DONE ignored
    v_start(3, 3); v_run(1);
    add(0, 0, 0, 1, 0, 0, 1, 1, 1, 0);
    v_stall(1); v_run(4); v_run(1); v_done(1);
    add(0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    v_idle(1);
    // Stalled write to presented entry; forwarded write to next entry
    v_start(4, 3); v_run(1); v_run(4);
    add(1, 2, 4'hF, 0, 0, 0, 4, 1, 1, 0);
    add(1, 3, 4'hA, 0, 0, 1, 4'hA, 1, 1, 0);
    v_run(5); v_done(5); v_idle(5);
    v_start(3, 3); v_run(1); v_run(4'hF); v_run(4'hA); v_done(4'hA); v_idle(4'hA);
    // Forwarding into the start load of entry 0
    add(1, 0, 7, 1, 2, 1, 7, 1, 1, 0);
    v_run(1); v_run(4'hF); v_done(4'hF); v_idle(4'hF);
    // Single-word replay
    v_start(0, 7); v_done(7); v_idle(7);

    rst = 1'b1;
    ifa.wr_en = 0; ifa.wr_addr = 0; ifa.wr_data = 0; ifa.start = 0; ifa.last_idx = 0; ifa.out_ready = 0;
    ifb.wr_en = 0; ifb.wr_addr = 0; ifb.wr_data = 0; ifb.start = 0; ifb.last_idx = 0; ifb.out_ready = 0;
    #2;
    check("reset_a", outs_a(), 7'h00);
    check("reset_b", outs_b(), 7'h00);
    step();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      ifa.wr_en     = tbl[i].we;
      ifa.wr_addr   = tbl[i].wa;
      ifa.wr_data   = tbl[i].wd;
      ifa.start     = tbl[i].st;
      ifa.last_idx  = tbl[i].li;
      ifa.out_ready = tbl[i].rdy;
      step();
      check($sformatf("vec%0d", i), outs_a(), {tbl[i].ed, tbl[i].ev, tbl[i].eb, tbl[i].edn});
    end
    ifa.wr_en = 0; ifa.start = 0;

    // Reset mid-replay after 3 transfers (entries now 7,1,F,A,5,9,2,6)
    ifa.start = 1; ifa.last_idx = 7; ifa.out_ready = 1;
    step();
    ifa.start = 0;
    check("midrun_word0", outs_a(), {4'h7, 3'b110});
    repeat (3) step();
    check("midrun_word3", outs_a(), {4'hA, 3'b110});
    #2 rst = 1'b1;
    #1 check("midrun_async_rst", outs_a(), 7'h00);
    #2 rst = 1'b0;
    ifa.start = 1; ifa.last_idx = 7;
    step();
    ifa.start = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("post_rst_word%0d", k), outs_a(), {4'h0, 3'b110});
      step();
    end
    check("post_rst_done", outs_a(), {4'h0, 3'b001});

    // DEPTH=6: out-of-range writes ignored, last_idx clamped to 5
    wr_b(6, 5); wr_b(7, 5); wr_b(5, 4'hC); wr_b(0, 1);
    exp_b = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC};
    ifb.start = 1; ifb.last_idx = 7; ifb.out_ready = 1;
    step();
    ifb.start = 0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("clamp_word%0d", k), outs_b(), {exp_b[k], 3'b110});
      step();
    end
    check("clamp_done", outs_b(), {4'hC, 3'b001});
    step();
    check("clamp_idle", outs_b(), {4'hC, 3'b000});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
